// File: rtl/fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// fetch_stage_pkg
//
// Shared types for the fetch stage and its skid buffer.
//
// Contents:
//   XLEN / ILEN        address-path and instruction widths (32 bits)
//   addr_t / insn_t    address and instruction word types
//   NOP_INSN_DEFAULT   addi x0,x0,0, the bubble placed on the decode input
//   PC_STEP            sequential fetch increment
//   ifidSel_e          where the IF/ID register takes its next value from
//   ifidEntry_t        contents of the IF/ID pipeline register
//   alignPc()          forces an address onto a word boundary
// ---------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [ILEN-1:0] insn_t;

    localparam insn_t NOP_INSN_DEFAULT = 32'h0000_0013;
    localparam addr_t PC_STEP          = 32'd4;

    // Source of the next IF/ID value. A flush and a bubble both produce an
    // invalid NOP; a flush also throws away whatever is buffered.
    typedef enum logic [2:0] {
        IFID_HOLD,
        IFID_FLUSH,
        IFID_FROM_SKID,
        IFID_FROM_MEM,
        IFID_BUBBLE
    } ifidSel_e;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        insn_t insn;
    } ifidEntry_t;

    // Instruction fetch is word based, so the two low address bits of a
    // redirect target carry no meaning and are cleared.
    function automatic addr_t alignPc(input addr_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer
//
// One-entry holding register for an instruction memory response that
// arrives while decode is stalled. The request logic in the top module
// never issues a fetch while this buffer is full, so at most one response
// ever needs to be caught.
//
// Ports:
//   clk      clock, all state on the rising edge
//   rst      synchronous active-high reset, empties the buffer
//   clear_i  drop any held entry (wrong-path flush); wins over load/drain
//   load_i   capture insn_i/pc_i; wins over drain so that a drain and a
//            refill in the same cycle leave the new entry held
//   drain_i  the held entry has been consumed
//   insn_i   instruction word to capture
//   pc_i     address of insn_i
//   valid_o  buffer holds an entry
//   insn_o   held instruction word
//   pc_o     address of the held instruction
// ---------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  clear_i,
    input  logic  load_i,
    input  logic  drain_i,
    input  insn_t insn_i,
    input  addr_t pc_i,
    output logic  valid_o,
    output insn_t insn_o,
    output addr_t pc_o
);

    logic  valid_q, valid_d;
    insn_t insn_q,  insn_d;
    addr_t pc_q,    pc_d;

    // Next-state selection: a clear always empties the buffer, a load
    // always fills it, and a drain on its own just marks it empty. The
    // data fields only change on a load.
    always_comb begin
        valid_d = valid_q;
        insn_d  = insn_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            insn_d  = insn_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            insn_q  <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            insn_q  <= insn_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign insn_o  = insn_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with the IF/ID pipeline register built in. It owns
// the fetch PC, issues at most one read per cycle to a synchronous
// instruction memory with one cycle of read latency, holds its output while
// the hazard controller stalls, and flushes wrong-path work on a taken
// branch or jump. A one-entry skid buffer catches the response that is
// already in flight when a stall arrives, so no instruction is lost or
// fetched twice.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   NOP_INSN    encoding driven on insn whenever valid is low
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   imemReq     read request to instruction memory
//   imemAddr    word-aligned fetch address, meaningful while imemReq=1
//   imemData    read data, valid the cycle after an accepted request
//   stall       hold the IF/ID contents
//   redirect    taken branch/jump: flush and refetch from redirectPc
//   redirectPc  redirect target, low two bits ignored
//   insn        instruction presented to decode
//   pc          address of insn
//   valid       insn/pc hold a real instruction
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter addr_t RESET_PC = 32'h0000_0000,
    parameter insn_t NOP_INSN = NOP_INSN_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemData,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic [31:0] insn,
    output logic [31:0] pc,
    output logic        valid
);

    addr_t      fpc_q,        fpc_d;
    logic       inflight_q,   inflight_d;
    addr_t      inflightPc_q, inflightPc_d;
    ifidEntry_t ifid_q,       ifid_d;
    ifidSel_e   ifidSel;

    logic       skidValid;
    insn_t      skidInsn;
    addr_t      skidPc;
    logic       skidLoad;
    logic       skidDrain;
    logic       skidClear;

    // A new fetch is only issued when its response is guaranteed a home:
    // not while decode is stalled, not on the redirect cycle (the old fpc
    // is wrong-path), and not while the skid buffer still holds a word.
    assign imemReq  = !rst && !stall && !redirect && !skidValid;
    assign imemAddr = fpc_q;

    // Fetch PC and in-flight tracking. A redirect overrides the sequential
    // increment; imemReq is already low in that cycle so nothing is marked
    // in flight. The increment wraps naturally at 2^32.
    always_comb begin
        fpc_d        = fpc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        if (redirect) begin
            fpc_d = alignPc(redirectPc);
        end else if (imemReq) begin
            fpc_d        = fpc_q + PC_STEP;
            inflight_d   = 1'b1;
            inflightPc_d = fpc_q;
        end
    end

    // Decide where the IF/ID register is loaded from. Redirect beats stall
    // so that a flush is never lost behind a hazard; an older buffered word
    // always goes out before a fresh memory response.
    always_comb begin
        ifidSel = IFID_BUBBLE;
        if (redirect) begin
            ifidSel = IFID_FLUSH;
        end else if (stall) begin
            ifidSel = IFID_HOLD;
        end else if (skidValid) begin
            ifidSel = IFID_FROM_SKID;
        end else if (inflight_q) begin
            ifidSel = IFID_FROM_MEM;
        end
    end

    // IF/ID next value. A bubble keeps the previous pc so that decode
    // always sees a stable address even when nothing is valid.
    always_comb begin
        ifid_d = ifid_q;
        case (ifidSel)
            IFID_HOLD: begin
                ifid_d = ifid_q;
            end
            IFID_FLUSH: begin
                ifid_d.valid = 1'b0;
                ifid_d.insn  = NOP_INSN;
            end
            IFID_FROM_SKID: begin
                ifid_d.valid = 1'b1;
                ifid_d.pc    = skidPc;
                ifid_d.insn  = skidInsn;
            end
            IFID_FROM_MEM: begin
                ifid_d.valid = 1'b1;
                ifid_d.pc    = inflightPc_q;
                ifid_d.insn  = imemData;
            end
            default: begin
                ifid_d.valid = 1'b0;
                ifid_d.insn  = NOP_INSN;
            end
        endcase
    end

    // Skid control. A response that cannot go straight into IF/ID (decode
    // stalled, or an older word is being drained first) is parked in the
    // buffer; a redirect discards whatever is parked.
    assign skidClear = redirect;
    assign skidLoad  = inflight_q && (stall || skidValid);
    assign skidDrain = !stall && skidValid;

    fetch_skid_buffer u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (skidClear),
        .load_i  (skidLoad),
        .drain_i (skidDrain),
        .insn_i  (imemData),
        .pc_i    (inflightPc_q),
        .valid_o (skidValid),
        .insn_o  (skidInsn),
        .pc_o    (skidPc)
    );

    // Stage state register. Reset drops any pending response by clearing
    // the in-flight flag, so a word returning after reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q        <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            ifid_q.valid <= 1'b0;
            ifid_q.pc    <= '0;
            ifid_q.insn  <= NOP_INSN;
        end else begin
            fpc_q        <= fpc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            ifid_q       <= ifid_d;
        end
    end

    assign insn  = ifid_q.insn;
    assign pc    = ifid_q.pc;
    assign valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. A synchronous instruction memory
// returns a fixed function of the address one cycle after each request and
// random junk otherwise. A transaction-level model tracks fetched addresses
// as queues (requested, arrived-but-undelivered) and predicts the outputs
// every cycle. Directed scenarios come first, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] imemData;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] insn;
    logic [31:0] pc;
    logic        valid;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mFpc   = RESET_PC;
    logic        mValid = 1'b0;
    logic [31:0] mPc    = 32'h0;
    logic [31:0] mInsn  = NOP;
    logic [31:0] reqQ[$];
    logic [31:0] bufQ[$];

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSN (NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemData   (imemData),
        .stall      (stall),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .insn       (insn),
        .pc         (pc),
        .valid      (valid)
    );

    // Memory contents: distinct from the address so a pc/insn swap shows up.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    // Synchronous instruction memory with one cycle of read latency; data
    // on cycles without a request is junk the stage must never use.
    always @(posedge clk) begin
        if (imemReq) imemData <= memWord(imemAddr);
        else         imemData <= $urandom;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Reference model advance for one clock edge. Fetched addresses move
    // from the request queue to the arrived queue after a cycle; decode
    // takes the oldest arrived word whenever it is not stalled.
    task automatic modelStep(input logic r, input logic s, input logic d,
                             input logic [31:0] tgt, input logic req);
        if (r) begin
            mFpc   = RESET_PC;
            reqQ.delete();
            bufQ.delete();
            mValid = 1'b0;
            mInsn  = NOP;
            mPc    = 32'h0;
            return;
        end
        if (d) begin
            mFpc   = {tgt[31:2], 2'b00};
            reqQ.delete();
            bufQ.delete();
            mValid = 1'b0;
            mInsn  = NOP;
            return;
        end
        if (reqQ.size() > 0) bufQ.push_back(reqQ.pop_front());
        if (!s) begin
            if (bufQ.size() > 0) begin
                mPc    = bufQ.pop_front();
                mInsn  = memWord(mPc);
                mValid = 1'b1;
            end else begin
                mValid = 1'b0;
                mInsn  = NOP;
            end
        end
        if (req) begin
            reqQ.push_back(mFpc);
            mFpc = mFpc + 32'd4;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare the DUT
    // with the model, then advance the model across the rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic d, input logic [31:0] tgt);
        logic expReq;
        @(negedge clk);
        rst        = r;
        stall      = s;
        redirect   = d;
        redirectPc = tgt;
        #1;
        expReq = !r && !s && !d && (bufQ.size() == 0);
        checkOutput("valid", 32'(valid), 32'(mValid));
        checkOutput("insn", insn, mInsn);
        if (mValid) checkOutput("pc", pc, mPc);
        checkOutput("imemReq", 32'(imemReq), 32'(expReq));
        if (expReq) checkOutput("imemAddr", imemAddr, mFpc);
        @(posedge clk);
        modelStep(r, s, d, tgt, expReq);
    endtask

    initial begin
        logic        r;
        logic        s;
        logic        d;
        logic [31:0] tgt;

        rst        = 1'b1;
        stall      = 1'b0;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        repeat (2) @(posedge clk);

        // Reset state, then sequential streaming from RESET_PC.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Three-cycle stall while streaming.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Redirect while streaming.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Fill the skid, then redirect and stall together.
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Address wrap past 32'hFFFF_FFFC, then a misaligned target.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF4);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a stall with a full skid.
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized stalls, redirects and occasional resets.
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(99) == 0);
            s   = ($urandom_range(3) == 0);
            d   = ($urandom_range(11) == 0);
            tgt = $urandom;
            if ($urandom_range(7) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
            applyStimulus(r, s, d, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
